// File: rtl/deco_nto2n_reg.sv
// Registered N-to-2^N one-hot decoder with valid/ready handshake and delivered-decode counter.
// Optional sweep mode (walks every output line in order) is built when DECO_SWEEP_EN is defined.
module deco_nto2n_reg #(
    parameter int unsigned N     = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [N-1:0]      in_sel,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   out_onehot,
    output logic              busy,
    output logic [CNT_W-1:0]  dec_count
`ifdef DECO_SWEEP_EN
    ,
    input  logic              sweep_start
`endif
);

    localparam int unsigned W = 2 ** N;

    logic          valid_q, valid_d;
    logic [W-1:0]  onehot_q, onehot_d;
    logic [CNT_W-1:0] cnt_q;
    logic          in_xfer;
    logic          out_xfer;

    // Shift-based decode avoids an index that is one bit wider than the output vector.
    function automatic logic [W-1:0] decode(input logic [N:0] code);
        return {{(W-1){1'b0}}, 1'b1} << code;
    endfunction

    assign in_ready  = !busy && (!valid_q || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = valid_q && out_ready;

    assign out_valid  = valid_q;
    assign out_onehot = onehot_q;
    assign dec_count  = cnt_q;

`ifdef DECO_SWEEP_EN
    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e        state_q, state_d;
    logic [N:0]    idx_q, idx_d;
    logic          sweep_go;

    // An input request in the same cycle takes priority over starting a sweep.
    assign sweep_go = (state_q == StIdle) && sweep_start && in_ready && !in_valid;
    assign busy     = (state_q == StSweep);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        unique case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    onehot_d = decode({1'b0, in_sel});
                    valid_d  = 1'b1;
                end else if (sweep_go) begin
                    onehot_d = decode('0);
                    valid_d  = 1'b1;
                    idx_d    = (N+1)'(1);
                    state_d  = StSweep;
                end else if (out_xfer) begin
                    valid_d = 1'b0;
                end
            end
            StSweep: begin
                if (out_xfer) begin
                    // idx_q[N] set means the last code (2^N-1) is the one leaving now.
                    if (!idx_q[N]) begin
                        onehot_d = decode(idx_q);
                        idx_d    = idx_q + (N+1)'(1);
                    end else begin
                        valid_d = 1'b0;
                        idx_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        valid_d  = valid_q;
        onehot_d = onehot_q;
        if (in_xfer) begin
            onehot_d = decode({1'b0, in_sel});
            valid_d  = 1'b1;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            onehot_q <= '0;
        end else begin
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    a_onehot_when_valid: assert property (@(posedge clk) disable iff (rst)
        valid_q |-> $onehot(onehot_q));

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
        (valid_q && !out_ready) |=> (valid_q && $stable(onehot_q)));

    a_no_accept_while_busy: assert property (@(posedge clk) disable iff (rst)
        busy |-> !in_ready);

endmodule

// File: tb/tb_deco_nto2n_reg.sv
// Bench for deco_nto2n_reg: directed vectors, literal checks and a transaction-level reference model.
module tb_deco_nto2n_reg;

    localparam int unsigned N     = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned W     = 2 ** N;
`ifdef DECO_SWEEP_EN
    localparam bit SweepEn = 1'b1;
`else
    localparam bit SweepEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [N-1:0]     in_sel;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_onehot;
    logic             busy;
    logic [CNT_W-1:0] dec_count;
    logic             sweep_start;

    deco_nto2n_reg #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .busy       (busy),
        .dec_count  (dec_count)
`ifdef DECO_SWEEP_EN
        ,
        .sweep_start(sweep_start)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: current code held, pending sweep codes, transfer count.
    bit m_live  = 1'b0;
    bit m_valid = 1'b0;
    bit m_zero  = 1'b1;
    bit m_busy  = 1'b0;
    int m_code  = 0;
    int m_count = 0;
    int sweep_q[$];

    always @(posedge clk) begin : model
        bit rdy;
        bit ox;
        if (rst) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_zero  = 1'b1;
            m_busy  = 1'b0;
            m_count = 0;
            sweep_q.delete();
        end else if (m_live) begin
            rdy = !m_busy && (!m_valid || out_ready);
            ox  = m_valid && out_ready;
            if (ox) m_count = (m_count + 1) % (2 ** CNT_W);
            if (in_valid && rdy) begin
                m_code  = int'(in_sel);
                m_valid = 1'b1;
                m_zero  = 1'b0;
            end else if (SweepEn && sweep_start && rdy && !in_valid) begin
                m_code  = 0;
                m_valid = 1'b1;
                m_zero  = 1'b0;
                m_busy  = 1'b1;
                for (int k = 1; k < int'(W); k++) sweep_q.push_back(k);
            end else if (ox) begin
                if (m_busy && sweep_q.size() > 0) begin
                    m_code = sweep_q.pop_front();
                end else begin
                    m_valid = 1'b0;
                    m_busy  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmp_in_ready", in_ready, !m_busy && (!m_valid || out_ready));
            chk("cmp_out_valid", out_valid, m_valid);
            chk("cmp_busy", busy, m_busy);
            chk("cmp_dec_count", dec_count, m_count);
            if (m_zero) chk("cmp_onehot_reset", out_onehot, 0);
            else if (m_valid) chk("cmp_onehot", out_onehot, 1 << m_code);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_onehot"}, out_onehot, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_dec_count"}, dec_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] rec [3];
    int got;

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sel      = '0;
        out_ready   = 1'b0;
        sweep_start = 1'b0;
        cyc();
        cyc();
        check_reset_state("init_rst");

        // Back-to-back decodes of codes 0..3 with the consumer always ready.
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel = N'(i);
            cyc();
            chk("stream_onehot", out_onehot, 1 << i);
            chk("stream_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_count", dec_count, 4);
        chk("stream_drained", out_valid, 0);

        // Backpressure: value held while in_sel wanders.
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        out_ready = 1'b0;
        cyc();
        chk("bp_load", out_onehot, 8'h04);
        for (int i = 0; i < 5; i++) begin
            in_sel = N'(i + 3);
            cyc();
            chk("bp_hold", out_onehot, 8'h04);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", in_ready, 1);
        cyc();
        chk("bp_one_xfer", dec_count, 5);
        cyc();
        chk("bp_no_second", dec_count, 5);
        chk("bp_drained", out_valid, 0);

        // Input request and sweep_start together: the input wins.
        in_valid    = 1'b1;
        in_sel      = 3'd1;
        sweep_start = 1'b1;
        out_ready   = 1'b0;
        cyc();
        chk("simul_onehot", out_onehot, 8'h02);
        chk("simul_busy", busy, 0);
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        out_ready   = 1'b1;
        cyc();
        chk("simul_count", dec_count, 6);
        chk("simul_busy_after", busy, 0);

`ifdef DECO_SWEEP_EN
        // Full sweep with the consumer always ready.
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        chk("sweep_first", out_onehot, 8'h01);
        chk("sweep_busy", busy, 1);
        chk("sweep_in_ready", in_ready, 0);
        for (int k = 1; k < int'(W); k++) begin
            cyc();
            chk("sweep_code", out_onehot, 1 << k);
            chk("sweep_busy", busy, 1);
            chk("sweep_in_ready", in_ready, 0);
        end
        cyc();
        chk("sweep_end_busy", busy, 0);
        chk("sweep_end_valid", out_valid, 0);
        chk("sweep_count", dec_count, 14);

        // Sweep under random stalls, reset after the third delivered code.
        sweep_start = 1'b1;
        out_ready   = 1'b0;
        cyc();
        sweep_start = 1'b0;
        got = 0;
        for (int c = 0; c < 200 && got < 3; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                rec[got] = out_onehot;
                got++;
            end
            cyc();
        end
        chk("stall_xfers", got, 3);
        for (int i = 0; i < 3; i++) chk("stall_order", rec[i], 1 << i);
        chk("stall_busy_pre_rst", busy, 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();
        check_reset_state("sweep_rst");
        rst = 1'b0;
        cyc();
        chk("sweep_rst_idle", busy, 0);
`endif

        // Reset while a transfer is pending and another is offered.
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        out_ready = 1'b0;
        cyc();
        chk("mid_load", out_onehot, 8'h20);
        rst       = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();
        check_reset_state("mid_rst");

        // Counter wrap at 2^CNT_W transfers.
        rst      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_sel = N'(i);
            cyc();
        end
        chk("wrap_15", dec_count, 15);
        in_valid = 1'b0;
        cyc();
        chk("wrap_0", dec_count, 0);
        chk("wrap_drained", out_valid, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deco_nto2n_reg.md
# deco_nto2n_reg

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready handshake on input and output. It generalises the combinational 2-to-4 decoder to any select width. It holds its output under backpressure and keeps a running count of delivered decodes. An optional sweep mode walks every output line in order, one transfer at a time, for lamp-test and bring-up of downstream select logic.

## Interface
- `N`, default 2: select width; output width is `2**N` (supported range 1..8).
- `CNT_W`, default 16: width of the delivered-decode counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_sel` holds a request.
- `in_sel`  in  N  code to decode.
- `in_ready`  out  1  block can accept a request this cycle.
- `out_valid`  out  1  `out_onehot` holds a decode.
- `out_ready`  in  1  consumer accepts `out_onehot` this cycle.
- `out_onehot`  out  2**N  one-hot result; bit k set for code k.
- `busy`  out  1  sweep in progress (0 when the sweep is compiled out).
- `dec_count`  out  CNT_W  number of output transfers since reset, wrapping.
- `sweep_start`  in  1  request a full sweep. Present only with `DECO_SWEEP_EN`.

## Operation
- Reset (`rst`=1 at the edge) sets outputs as follows:
  - `out_onehot`=0, `out_valid`=0, `dec_count`=0, `busy`=0.
  - FSM goes to IDLE and the sweep index goes to 0.
  - Reset wins over every other event, including mid-sweep and mid-transfer.
- The output is a one-entry register.
  - `in_ready` = `!busy && (!out_valid || out_ready)`, combinational.
  - An input transfer occurs when `in_valid && in_ready`. The register loads `1 << in_sel` and sets `out_valid`=1.
- An output transfer occurs when `out_valid && out_ready`.
  - Without a same-cycle load, `out_valid` clears.
  - `dec_count` increments by 1 and wraps modulo 2^CNT_W.
- While `out_valid && !out_ready`, `out_onehot` is held bit-stable. Changes on `in_sel` are ignored.
- `out_onehot` always has exactly one bit set when `out_valid`=1. It is zero only after reset, before the first load.
- The FSM has two states, IDLE and SWEEP.
  - IDLE → SWEEP: `sweep_start`=1, `in_ready`=1 and `in_valid`=0. The register loads code 0, the index loads 1, and `busy` goes to 1.
  - In SWEEP, each output transfer with index < 2^N loads `1 << index` and increments the index.
  - SWEEP → IDLE: output transfer of code 2^N−1. `out_valid` clears and `busy` clears.
  - The index is N+1 bits wide, so 2^N is representable.
- Simultaneous events:
  - If `in_valid` and `sweep_start` are high together in IDLE, the input request is accepted. `sweep_start` is ignored and must be re-presented.
  - `sweep_start` is ignored while in SWEEP.

## Timing
- Latency is 1 cycle: a decode accepted at edge t is visible with `out_valid`=1 after edge t.
- Throughput is 1 transfer per cycle when `out_ready` is held high; load and unload happen in the same cycle.
- `in_ready` depends combinationally on `out_ready` and on nothing else from the input side.
- A sweep delivers 2^N transfers. With `out_ready` held high it takes 2^N+1 cycles from `sweep_start` until `busy` falls.
- `in_ready`=0 for the whole duration of `busy`=1.

## Configuration
- `DECO_SWEEP_EN` defined:
  - The `sweep_start` port exists.
  - The SWEEP state and sweep index are built, and `busy` behaves as above.
- `DECO_SWEEP_EN` undefined:
  - The `sweep_start` port is absent.
  - The FSM and index are not generated, and `busy` is tied to 0.
  - The handshake, decode and counter behaviour are identical in both builds.

## Test plan
- Reset: drive `rst`=1 for 2 cycles mid-transfer. Required: `out_onehot`=0, `out_valid`=0, `dec_count`=0, `busy`=0, `in_ready`=1.
- N=2, `out_ready`=1, `in_sel` = 0,1,2,3 on consecutive cycles. Required: `out_onehot` = 0001, 0010, 0100, 1000 one cycle later each, and `dec_count`=4.
- Backpressure: load `in_sel`=2, hold `out_ready`=0 for 5 cycles while `in_sel` toggles. Required: `out_onehot`=0100 stable and `in_ready`=0. Then `out_ready`=1 gives exactly one transfer.
- N=3 with `DECO_SWEEP_EN`: pulse `sweep_start` in IDLE with `out_ready`=1. Required: 8 transfers 0x01, 0x02 … 0x80, `busy` high for 8 cycles, `in_ready`=0 throughout, then IDLE.
- Sweep with random `out_ready` stalls, then `rst` asserted after the 3rd transfer. Required: no code skipped or repeated before reset; all outputs at reset values afterwards.
- `in_valid`=1 (`in_sel`=1) and `sweep_start`=1 in the same IDLE cycle. Required: single decode 0010 and `busy` stays 0. Counter wrap check with `CNT_W`=4: 16 transfers give `dec_count`=0.
